// File: rtl/vmem_pkg.sv
// Shared types and constants for the vector memory port arbiter.
package vmem_pkg;

    localparam int NUM_REQ    = 3;
    localparam int REQ_SCALAR = 0;
    localparam int REQ_VLD    = 1;
    localparam int REQ_VST    = 2;

    // Default field widths; the arbiter parameters default to these values.
    localparam int VMEM_ADDR_WIDTH    = 32;
    localparam int VMEM_DATA_WIDTH    = 256;
    localparam int VMEM_MICROOP_WIDTH = 5;
    localparam int VMEM_TICKET_BITS   = 4;
    localparam int VMEM_SZW           = $clog2(VMEM_DATA_WIDTH / 8) + 1;

    typedef logic [1:0] req_id_t;

    typedef struct packed {
        logic [VMEM_ADDR_WIDTH-1:0]    addr;
        logic [VMEM_MICROOP_WIDTH-1:0] microop;
        logic [VMEM_SZW-1:0]           size;
        logic [VMEM_TICKET_BITS-1:0]   ticket;
        logic [VMEM_DATA_WIDTH-1:0]    data;
    } vmem_req_t;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

    // Next requester id in round-robin order, wrapping 2 -> 0.
    function automatic req_id_t rr_next(input req_id_t id);
        return (id == 2'd2) ? 2'd0 : id + 2'd1;
    endfunction

endpackage

// File: rtl/vmem_tag_fifo.sv
// In-order FIFO of requester ids for loads awaiting a cache response.
// Push while full is accepted only when a pop happens in the same cycle.
module vmem_tag_fifo
    import vmem_pkg::*;
#(
    parameter int DW    = 2,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [DW-1:0]            push_data_i,
    input  logic                     pop_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [DW-1:0]            head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;

    logic w_push;
    logic w_pop;

    assign full_o  = (r_count == (PW+1)'(DEPTH));
    assign empty_o = (r_count == '0);
    assign head_o  = r_mem[r_rd_ptr];
    assign count_o = r_count;

    assign w_pop  = pop_i & ~empty_o;
    assign w_push = push_i & (~full_o | w_pop);

    // Tag storage; contents are meaningless while the entry is not counted.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/vmem_port_arbiter.sv
// Shares the single D-cache request port between the scalar LSU and the
// vector load/store engines. Round-robin with optional burst lock, and an
// in-order tag FIFO that steers load responses back to their source.
module vmem_port_arbiter
    import vmem_pkg::*;
#(
    parameter int ADDR_WIDTH      = VMEM_ADDR_WIDTH,
    parameter int REQ_DATA_WIDTH  = VMEM_DATA_WIDTH,
    parameter int MICROOP_WIDTH   = VMEM_MICROOP_WIDTH,
    parameter int TICKET_BITS     = VMEM_TICKET_BITS,
    parameter int MAX_OUTSTANDING = 4,
    parameter int MAX_BURST       = 8,
    localparam int SZW            = $clog2(REQ_DATA_WIDTH / 8) + 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_REQ-1:0]                  req_valid_i,
    input  logic [NUM_REQ-1:0]                  req_lock_i,
    input  logic [NUM_REQ-1:0]                  req_is_load_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]       req_addr_i,
    input  logic [NUM_REQ*MICROOP_WIDTH-1:0]    req_microop_i,
    input  logic [NUM_REQ*SZW-1:0]              req_size_i,
    input  logic [NUM_REQ*TICKET_BITS-1:0]      req_ticket_i,
    input  logic [NUM_REQ*REQ_DATA_WIDTH-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]                  grant_o,
    output logic                                mem_req_valid_o,
    output logic [ADDR_WIDTH-1:0]               mem_req_addr_o,
    output logic [MICROOP_WIDTH-1:0]            mem_req_microop_o,
    output logic [SZW-1:0]                      mem_req_size_o,
    output logic [TICKET_BITS-1:0]              mem_req_ticket_o,
    output logic [REQ_DATA_WIDTH-1:0]           mem_req_data_o,
    input  logic                                cache_ready_i,
    input  logic                                mem_resp_valid_i,
    input  logic [REQ_DATA_WIDTH-1:0]           mem_resp_data_i,
    output logic [NUM_REQ-1:0]                  resp_valid_o,
    output logic                                busy_o
);

    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam int CNT_W   = $clog2(MAX_OUTSTANDING) + 1;

    arb_state_e         r_state;
    req_id_t            r_owner;
    req_id_t            r_rr_ptr;
    logic [BURST_W-1:0] r_burst_cnt;

    arb_state_e         w_state_nxt;
    req_id_t            w_owner_nxt;
    req_id_t            w_rr_nxt;
    logic [BURST_W-1:0] w_burst_nxt;

    logic [NUM_REQ-1:0] w_grant;
    logic [NUM_REQ-1:0] w_elig;
    req_id_t            w_win;
    req_id_t            w_cand;
    logic               w_found;

    logic               w_fifo_full;
    logic               w_fifo_empty;
    req_id_t            w_fifo_head;
    logic [CNT_W-1:0]   w_fifo_count;
    logic               w_push;
    logic               w_pop;

    vmem_req_t          w_req [NUM_REQ];
    vmem_req_t          w_sel;

    // Response data is consumed directly by the requesters; only the valid is routed here.
    logic               w_unused_resp;
    assign w_unused_resp = ^mem_resp_data_i;

    // Unpack the flat per-requester buses into request records.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_req[i].addr    = req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            w_req[i].microop = req_microop_i[i*MICROOP_WIDTH +: MICROOP_WIDTH];
            w_req[i].size    = req_size_i[i*SZW +: SZW];
            w_req[i].ticket  = req_ticket_i[i*TICKET_BITS +: TICKET_BITS];
            w_req[i].data    = req_data_i[i*REQ_DATA_WIDTH +: REQ_DATA_WIDTH];
        end
    end

    // A pop frees a slot in the same cycle, so a load may still be granted when full.
    assign w_pop = mem_resp_valid_i & ~w_fifo_empty;

    // A requester is grantable when the cache is ready and, for loads, a tag slot is available.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_elig[i] = cache_ready_i & req_valid_i[i]
                      & (~req_is_load_i[i] | ~w_fifo_full | w_pop);
        end
    end

    // Arbitration state, owner, burst length and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_owner     <= '0;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_burst_cnt <= w_burst_nxt;
        end
    end

    // Winner selection and next-state logic; grants are combinational.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr_ptr;
        w_burst_nxt = r_burst_cnt;
        w_grant     = '0;
        w_win       = r_rr_ptr;
        w_cand      = r_rr_ptr;
        w_found     = 1'b0;
        case (r_state)
            IDLE: begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (!w_found && w_elig[w_cand]) begin
                        w_found = 1'b1;
                        w_win   = w_cand;
                    end
                    w_cand = rr_next(w_cand);
                end
                if (w_found) begin
                    w_grant[w_win] = 1'b1;
                    w_rr_nxt       = rr_next(w_win);
                    // A one-grant burst limit means a lock never holds beyond this grant.
                    if (req_lock_i[w_win] && (MAX_BURST > 1)) begin
                        w_state_nxt = OWNED;
                        w_owner_nxt = w_win;
                        w_burst_nxt = BURST_W'(1);
                    end
                end
            end
            OWNED: begin
                w_win = r_owner;
                if (w_elig[r_owner]) begin
                    w_found          = 1'b1;
                    w_grant[r_owner] = 1'b1;
                    w_rr_nxt         = rr_next(r_owner);
                    w_burst_nxt      = r_burst_cnt + 1'b1;
                end
                // Dropping the lock releases whether or not the owner was granted;
                // an owner with no valid request simply waits.
                if (!req_lock_i[r_owner]
                    || (w_found && (r_burst_cnt == BURST_W'(MAX_BURST - 1)))) begin
                    w_state_nxt = IDLE;
                    w_burst_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_push = w_found & req_is_load_i[w_win];

    vmem_tag_fifo #(
        .DW    (2),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (w_push),
        .push_data_i (w_win),
        .pop_i       (w_pop),
        .full_o      (w_fifo_full),
        .empty_o     (w_fifo_empty),
        .head_o      (w_fifo_head),
        .count_o     (w_fifo_count)
    );

    // Route the response to the requester recorded at the FIFO head.
    always_comb begin
        resp_valid_o = '0;
        if (w_pop) begin
            resp_valid_o[w_fifo_head] = 1'b1;
        end
    end

    assign w_sel             = w_req[w_win];
    assign grant_o           = w_grant;
    assign mem_req_valid_o   = |w_grant;
    assign mem_req_addr_o    = w_found ? w_sel.addr    : '0;
    assign mem_req_microop_o = w_found ? w_sel.microop : '0;
    assign mem_req_size_o    = w_found ? w_sel.size    : '0;
    assign mem_req_ticket_o  = w_found ? w_sel.ticket  : '0;
    assign mem_req_data_o    = w_found ? w_sel.data    : '0;

    assign busy_o = (r_state == OWNED) | (w_fifo_count != '0);

    // A response with no load outstanding is dropped and flagged.
    a_resp_has_tag: assert property (@(posedge clk) disable iff (!rst_n)
        !(mem_resp_valid_i && w_fifo_empty));

endmodule
